// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C requester arbiter.
//   - FSM state encoding for the arbiter sequencer
//   - transaction field widths (byte count, device address, data byte)
//   - one-hot to index helper used to remember the previous owner
package i2c_arb_pkg;

  localparam int unsigned NB_W    = 6;
  localparam int unsigned DEV_W   = 7;
  localparam int unsigned BYTE_W  = 8;
  // Owner index width; covers the largest supported requester count.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArb      = 3'd1,
    StLaunch   = 3'd2,
    StWaitBusy = 3'd3,
    StRun      = 3'd4,
    StFinish   = 3'd5
  } arb_state_e;

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   in  NREQ   request vector
//   last  in  IDX_W  index of the previous owner; search starts at last+1
//   pick  out NREQ   one-hot winner, 0 when no request
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  pick
);

  logic found;

  // Walk offsets 1..NREQ from the previous owner; the previous owner itself is
  // visited last, which gives a re-asserting requester the lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == ((32'(last) + off) % NREQ))) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master between NREQ requesters with round-robin grant.
// The winner's transaction fields are latched, the master is started with a
// one-cycle m_go, byte strobes are routed between owner and master, and the
// owner receives a done pulse with its NACK/timeout flag.
// Optional feature macro: I2C_ARB_TIMEOUT_EN (watchdog of TMO_CYC cycles).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_go/rw/nbyte/dev/rptr    per-requester transaction request
//   req_wdata / req_wnext       owner write byte / consumed pulse
//   req_rdata / req_rvld        shared read byte / per-requester valid pulse
//   req_done / req_err          end-of-transaction pulse / error flag
//   grant                       one-hot current owner
//   m_go m_rw m_nbyte m_dev m_rptr m_dwr    master command and write byte
//   m_wnext m_drd m_rvld m_ready m_done m_ack_e  master status and read data
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TMO_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_go,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NB_W*NREQ-1:0]   req_nbyte,
  input  logic [DEV_W*NREQ-1:0]  req_dev,
  input  logic [BYTE_W*NREQ-1:0] req_rptr,
  input  logic [BYTE_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]        req_wnext,
  output logic [BYTE_W-1:0]      req_rdata,
  output logic [NREQ-1:0]        req_rvld,
  output logic [NREQ-1:0]        req_done,
  output logic [NREQ-1:0]        req_err,
  output logic [NREQ-1:0]        grant,
  output logic                   m_go,
  output logic                   m_rw,
  output logic [NB_W-1:0]        m_nbyte,
  output logic [DEV_W-1:0]       m_dev,
  output logic [BYTE_W-1:0]      m_rptr,
  output logic [BYTE_W-1:0]      m_dwr,
  input  logic                   m_wnext,
  input  logic [BYTE_W-1:0]      m_drd,
  input  logic                   m_rvld,
  input  logic                   m_ready,
  input  logic                   m_done,
  input  logic                   m_ack_e
);

  arb_state_e         state_q, state_d;
  logic [NREQ-1:0]    grant_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               err_q;
  logic [BYTE_W-1:0]  rdata_q;
  logic [NREQ-1:0]    rvld_q;
  logic               rw_q;
  logic [NB_W-1:0]    nbyte_q;
  logic [DEV_W-1:0]   dev_q;
  logic [BYTE_W-1:0]  rptr_q;

  logic [NREQ-1:0]    pick;
  logic               sel_rw;
  logic [NB_W-1:0]    sel_nbyte;
  logic [DEV_W-1:0]   sel_dev;
  logic [BYTE_W-1:0]  sel_rptr;
  logic               tmo_hit;

  i2c_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req (req_go),
    .last(ptr_q),
    .pick(pick)
  );

  // Field mux for the requester the picker selects this cycle.
  always_comb begin
    sel_rw    = 1'b0;
    sel_nbyte = '0;
    sel_dev   = '0;
    sel_rptr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        sel_rw    = req_rw[i];
        sel_nbyte = req_nbyte[i*NB_W +: NB_W];
        sel_dev   = req_dev[i*DEV_W +: DEV_W];
        sel_rptr  = req_rptr[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    m_dwr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) m_dwr = req_wdata[i*BYTE_W +: BYTE_W];
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        tmo_count;

  assign tmo_count = (state_q == StWaitBusy) || (state_q == StRun);
  assign tmo_hit   = tmo_count && (tmo_q == 32'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (state_q == StLaunch) begin
      tmo_q <= '0;
    end else if (tmo_count) begin
      tmo_q <= tmo_q + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    m_go    = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req_go) state_d = StArb;
      end
      StArb: begin
        // Requests may vanish between IDLE and ARB; zero-byte jobs skip the master.
        if (pick == '0)            state_d = StIdle;
        else if (sel_nbyte == '0)  state_d = StFinish;
        else                       state_d = StLaunch;
      end
      StLaunch: begin
        if (m_ready && m_done) begin
          m_go    = 1'b1;
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!m_done) state_d = StRun;
      end
      StRun: begin
        // m_done was seen low in WAIT_BUSY, so a high level here is its rising edge.
        if (m_done) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (tmo_hit) state_d = StFinish;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= '0;
      rw_q    <= 1'b0;
      nbyte_q <= '0;
      dev_q   <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      rvld_q  <= (state_q == StRun && m_rvld) ? grant_q : '0;
      if (state_q == StRun && m_rvld) rdata_q <= m_drd;
      case (state_q)
        StArb: begin
          grant_q <= pick;
          err_q   <= 1'b0;
          rw_q    <= sel_rw;
          nbyte_q <= sel_nbyte;
          dev_q   <= sel_dev;
          rptr_q  <= sel_rptr;
        end
        StRun: begin
          if (m_ack_e) err_q <= 1'b1;
        end
        StFinish: begin
          ptr_q   <= oh_to_idx(MAX_REQ'(grant_q));
          grant_q <= '0;
        end
        default: ;
      endcase
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign grant     = grant_q;
  assign req_wnext = (state_q == StRun && m_wnext) ? grant_q : '0;
  assign req_rdata = rdata_q;
  assign req_rvld  = rvld_q;
  assign req_done  = (state_q == StFinish) ? grant_q : '0;
  assign req_err   = (state_q == StFinish && err_q) ? grant_q : '0;
  assign m_rw      = rw_q;
  assign m_nbyte   = nbyte_q;
  assign m_dev     = dev_q;
  assign m_rptr    = rptr_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
module tb_i2c_req_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TMO_CYC = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_go, req_rw;
  logic [6*NREQ-1:0] req_nbyte;
  logic [7*NREQ-1:0] req_dev;
  logic [8*NREQ-1:0] req_rptr, req_wdata;
  logic [NREQ-1:0]   req_wnext, req_rvld, req_done, req_err, grant;
  logic [7:0]        req_rdata;
  logic              m_go, m_rw, m_wnext, m_rvld, m_ready, m_done, m_ack_e;
  logic [5:0]        m_nbyte;
  logic [6:0]        m_dev;
  logic [7:0]        m_rptr, m_dwr, m_drd;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NREQ(NREQ), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .reset(reset), .req_go(req_go), .req_rw(req_rw), .req_nbyte(req_nbyte),
    .req_dev(req_dev), .req_rptr(req_rptr), .req_wdata(req_wdata), .req_wnext(req_wnext),
    .req_rdata(req_rdata), .req_rvld(req_rvld), .req_done(req_done), .req_err(req_err),
    .grant(grant), .m_go(m_go), .m_rw(m_rw), .m_nbyte(m_nbyte), .m_dev(m_dev),
    .m_rptr(m_rptr), .m_dwr(m_dwr), .m_wnext(m_wnext), .m_drd(m_drd), .m_rvld(m_rvld),
    .m_ready(m_ready), .m_done(m_done), .m_ack_e(m_ack_e)
  );

  int checks = 0, failures = 0, cyc = 0;

  // Requester models
  logic            rst_drv;
  logic [NREQ-1:0] rq_go;
  logic            rq_rw[NREQ];
  logic [5:0]      rq_nb[NREQ];
  logic [6:0]      rq_dev[NREQ];
  logic [7:0]      rq_rptr[NREQ];
  logic [7:0]      wbytes[NREQ][64];
  int              rq_wptr[NREQ];

  // Master model
  logic mst_ready, mst_done, mst_wn, mst_rv, mst_ack;
  logic [7:0] mst_drd;
  int   mst_phase, mst_left;
  bit   mst_isrd, mst_err_inject, mst_both, mst_stuck;
  logic [7:0] rbytes[$];
  logic [7:0] mst_wr[$];

  // Observation logs
  int go_cnt, go_cyc;
  int done_cnt[NREQ], done_cyc[NREQ], wn_cnt[NREQ];
  logic done_err[NREQ];
  int order[$];
  logic [7:0] rd_log[NREQ][$];
  logic [NREQ-1:0] go_grant;
  logic go_rw;
  logic [5:0] go_nb;
  logic [6:0] go_dev;
  logic [7:0] go_rptr;

  // Reference round-robin state: index of the last requester served.
  int model_last;

  function automatic int rr_next(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int total_done();
    int s;
    s = 0;
    for (int i = 0; i < NREQ; i++) s += done_cnt[i];
    return s;
  endfunction

  task automatic master_idle();
    mst_phase = 0; mst_ready = 1'b1; mst_done = 1'b1;
    mst_wn = 1'b0; mst_rv = 1'b0; mst_ack = 1'b0;
  endtask

  task automatic master_issue();
    if (mst_left > 0) begin
      if ($urandom_range(0, 2) != 0) begin
        mst_wn = mst_isrd ? mst_both : 1'b1;
        mst_rv = mst_isrd;
        if (mst_isrd) mst_drd = (rbytes.size() > 0) ? rbytes.pop_front() : 8'($urandom);
        mst_ack = mst_err_inject;
        mst_err_inject = 1'b0;
        mst_left--;
      end
    end else begin
      mst_done = 1'b1; mst_ready = 1'b1; mst_phase = 0;
    end
  endtask

  // Drive at posedge+1, observe at negedge, then decide the next cycle.
  task automatic cycle();
    @(posedge clk); #1;
    reset  = rst_drv;
    req_go = rq_go;
    for (int i = 0; i < NREQ; i++) begin
      req_rw[i]          = rq_rw[i];
      req_nbyte[i*6 +: 6] = rq_nb[i];
      req_dev[i*7 +: 7]   = rq_dev[i];
      req_rptr[i*8 +: 8]  = rq_rptr[i];
      req_wdata[i*8 +: 8] = wbytes[i][rq_wptr[i] % 64];
    end
    m_ready = mst_ready; m_done = mst_done; m_wnext = mst_wn;
    m_rvld = mst_rv; m_drd = mst_drd; m_ack_e = mst_ack;
    @(negedge clk);
    cyc++;
    if (m_go === 1'b1) begin
      go_cnt++; go_cyc = cyc; go_grant = grant;
      go_rw = m_rw; go_nb = m_nbyte; go_dev = m_dev; go_rptr = m_rptr;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_done[i] === 1'b1) begin
        done_cnt[i]++; done_cyc[i] = cyc; done_err[i] = req_err[i];
        order.push_back(i); rq_go[i] = 1'b0;
      end
      if (req_rvld[i] === 1'b1) rd_log[i].push_back(req_rdata);
      if (req_wnext[i] === 1'b1) begin wn_cnt[i]++; rq_wptr[i]++; end
    end
    if (mst_wn) mst_wr.push_back(m_dwr);
    mst_wn = 1'b0; mst_rv = 1'b0; mst_ack = 1'b0;
    if (mst_phase == 0) begin
      if (m_go === 1'b1) begin
        mst_phase = 1; mst_left = int'(m_nbyte); mst_isrd = m_rw;
        mst_ready = 1'b0; mst_done = mst_stuck ? 1'b1 : 1'b0;
      end
    end else if (mst_phase == 1) begin
      if (!mst_stuck) begin mst_phase = 2; master_issue(); end
    end else begin
      master_issue();
    end
  endtask

  task automatic set_req(input int i, input logic rw, input logic [5:0] nb,
                         input logic [6:0] dev, input logic [7:0] rp);
    rq_rw[i] = rw; rq_nb[i] = nb; rq_dev[i] = dev; rq_rptr[i] = rp; rq_wptr[i] = 0;
    for (int k = 0; k < 64; k++) wbytes[i][k] = 8'($urandom);
    rq_go[i] = 1'b1;
  endtask

  task automatic wait_done(input int target, input int bound, output bit ok);
    int n;
    n = 0;
    while (total_done() < target && n < bound) begin cycle(); n++; end
    ok = (total_done() >= target);
  endtask

  task automatic test_reset();
    rst_drv = 1'b1; cycle(); cycle();
    rst_drv = 1'b0; cycle();
    checks++; if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b want=0", grant); end
    checks++; if (m_go !== 1'b0) begin failures++; $display("FAIL reset_m_go got=%b want=0", m_go); end
    checks++;
    if ({req_done, req_rvld, req_wnext, req_err} !== '0) begin
      failures++; $display("FAIL reset_pulses got=%h want=0", {req_done, req_rvld, req_wnext, req_err});
    end
    checks++; if (req_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h want=00", req_rdata); end
    model_last = 0;
  endtask

  task automatic test_write();
    int start, g0, w0; bit ok;
    g0 = go_cnt; w0 = wn_cnt[0]; mst_wr.delete();
    set_req(0, 1'b0, 6'd2, 7'h48, 8'h01);
    start = cyc + 1;
    wait_done(total_done() + 1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL write_done_timeout got=0 want=1"); end
    checks++; if (go_cyc - start != 2) begin failures++; $display("FAIL write_go_latency got=%0d want=2", go_cyc - start); end
    checks++; if (go_cnt - g0 != 1) begin failures++; $display("FAIL write_go_count got=%0d want=1", go_cnt - g0); end
    checks++;
    if ({go_rw, go_nb, go_dev, go_rptr} !== {1'b0, 6'd2, 7'h48, 8'h01}) begin
      failures++; $display("FAIL write_fields got=%h want=%h", {go_rw, go_nb, go_dev, go_rptr},
                           {1'b0, 6'd2, 7'h48, 8'h01});
    end
    checks++; if (go_grant !== 4'b0001) begin failures++; $display("FAIL write_grant got=%b want=0001", go_grant); end
    checks++; if (wn_cnt[0] - w0 != 2) begin failures++; $display("FAIL write_wnext got=%0d want=2", wn_cnt[0] - w0); end
    checks++;
    if (mst_wr.size() != 2) begin
      failures++; $display("FAIL write_bytes_n got=%0d want=2", mst_wr.size());
    end else if (mst_wr[0] !== wbytes[0][0] || mst_wr[1] !== wbytes[0][1]) begin
      failures++; $display("FAIL write_bytes got=%h%h want=%h%h", mst_wr[0], mst_wr[1], wbytes[0][0], wbytes[0][1]);
    end
    checks++; if (done_err[0] !== 1'b0) begin failures++; $display("FAIL write_err got=%b want=0", done_err[0]); end
    model_last = 0;
  endtask

  task automatic test_read();
    logic [7:0] exp[3];
    bit ok; int w1;
    exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = 8'hFF;
    rbytes.delete(); for (int k = 0; k < 3; k++) rbytes.push_back(exp[k]);
    rd_log[1].delete(); w1 = wn_cnt[1];
    set_req(1, 1'b1, 6'd3, 7'h1D, 8'h10);
    wait_done(total_done() + 1, 100, ok);
    checks++; if (!ok || done_cnt[1] != 1) begin failures++; $display("FAIL read_done got=%0d want=1", done_cnt[1]); end
    checks++; if (go_rw !== 1'b1 || go_grant !== 4'b0010) begin failures++; $display("FAIL read_cmd got=%b/%b want=1/0010", go_rw, go_grant); end
    checks++;
    if (rd_log[1].size() != 3) begin
      failures++; $display("FAIL read_count got=%0d want=3", rd_log[1].size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_log[1][k] !== exp[k]) begin failures++; $display("FAIL read_byte%0d got=%h want=%h", k, rd_log[1][k], exp[k]); end
      end
    end
    checks++; if (wn_cnt[1] != w1) begin failures++; $display("FAIL read_no_wnext got=%0d want=%0d", wn_cnt[1], w1); end
    checks++; if (done_err[1] !== 1'b0) begin failures++; $display("FAIL read_err got=%b want=0", done_err[1]); end
    model_last = 1;
  endtask

  task automatic test_nbyte0();
    int start, g0; bit ok;
    g0 = go_cnt;
    set_req(3, 1'b0, 6'd0, 7'h22, 8'h33);
    start = cyc + 1;
    wait_done(total_done() + 1, 20, ok);
    checks++; if (!ok || done_cyc[3] - start != 2) begin failures++; $display("FAIL nb0_latency got=%0d want=2", done_cyc[3] - start); end
    for (int n = 0; n < 5; n++) cycle();
    checks++; if (go_cnt != g0) begin failures++; $display("FAIL nb0_no_go got=%0d want=%0d", go_cnt, g0); end
    checks++; if (done_err[3] !== 1'b0) begin failures++; $display("FAIL nb0_err got=%b want=0", done_err[3]); end
    model_last = 3;
  endtask

  // One round: a set of requesters asserted together, order checked against the model.
  task automatic run_round(input logic [NREQ-1:0] mask, input string tag);
    int exp[$]; int d0, l, n; int wn0[NREQ], dc0[NREQ]; logic [NREQ-1:0] pend; bit ok;
    order.delete(); d0 = total_done();
    for (int k = 0; k < 16; k++) rbytes.push_back(8'($urandom));
    for (int i = 0; i < NREQ; i++) begin
      wn0[i] = wn_cnt[i]; dc0[i] = done_cnt[i];
      if (mask[i]) set_req(i, 1'($urandom), 6'($urandom_range(0, 4)), 7'($urandom), 8'($urandom));
    end
    pend = mask; l = model_last;
    while (pend != '0) begin n = rr_next(pend, l); exp.push_back(n); pend[n] = 1'b0; l = n; end
    model_last = l;
    wait_done(d0 + exp.size(), 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_timeout got=%0d want=%0d", tag, total_done() - d0, exp.size()); end
    checks++;
    if (order.size() != exp.size()) begin
      failures++; $display("FAIL %s_order_n got=%0d want=%0d", tag, order.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        checks++;
        if (order[k] != exp[k]) begin failures++; $display("FAIL %s_order%0d got=%0d want=%0d", tag, k, order[k], exp[k]); end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i] && !rq_rw[i]) begin
        checks++;
        if (wn_cnt[i] - wn0[i] != int'(rq_nb[i]) || done_cnt[i] - dc0[i] != 1) begin
          failures++; $display("FAIL %s_req%0d_wnext got=%0d want=%0d", tag, i, wn_cnt[i] - wn0[i], rq_nb[i]);
        end
      end
    end
  endtask

  task automatic test_all_req();
    run_round(4'b1111, "all");
    run_round(4'b0001, "again0");
  endtask

  task automatic test_ack_err();
    bit ok;
    mst_err_inject = 1'b1;
    set_req(2, 1'b0, 6'd2, 7'h50, 8'h02);
    wait_done(total_done() + 1, 100, ok);
    checks++; if (!ok || done_err[2] !== 1'b1) begin failures++; $display("FAIL ackerr_set got=%b want=1", done_err[2]); end
    set_req(2, 1'b0, 6'd1, 7'h50, 8'h03);
    wait_done(total_done() + 1, 100, ok);
    checks++; if (!ok || done_err[2] !== 1'b0) begin failures++; $display("FAIL ackerr_clear got=%b want=0", done_err[2]); end
    model_last = 2;
  endtask

  task automatic test_both_strobes();
    logic [7:0] exp[$]; int w1; bit ok;
    rbytes.delete(); rd_log[1].delete();
    for (int k = 0; k < 3; k++) begin exp.push_back(8'($urandom)); rbytes.push_back(exp[k]); end
    w1 = wn_cnt[1]; mst_both = 1'b1;
    set_req(1, 1'b1, 6'd3, 7'h11, 8'h44);
    wait_done(total_done() + 1, 100, ok);
    mst_both = 1'b0;
    checks++; if (wn_cnt[1] - w1 != 3) begin failures++; $display("FAIL both_wnext got=%0d want=3", wn_cnt[1] - w1); end
    checks++;
    if (rd_log[1].size() != 3) begin
      failures++; $display("FAIL both_rvld got=%0d want=3", rd_log[1].size());
    end else if (rd_log[1][0] !== exp[0] || rd_log[1][2] !== exp[2]) begin
      failures++; $display("FAIL both_rdata got=%h..%h want=%h..%h", rd_log[1][0], rd_log[1][2], exp[0], exp[2]);
    end
    model_last = 1;
  endtask

  task automatic test_drop_go();
    int g0, w0, d0, n; bit ok;
    g0 = go_cnt; w0 = wn_cnt[0]; d0 = done_cnt[0];
    set_req(0, 1'b0, 6'd3, 7'h3C, 8'h05);
    n = 0;
    while (go_cnt == g0 && n < 20) begin cycle(); n++; end
    rq_go[0] = 1'b0;
    wait_done(total_done() + 1, 100, ok);
    for (int k = 0; k < 10; k++) cycle();
    checks++; if (done_cnt[0] - d0 != 1) begin failures++; $display("FAIL drop_done got=%0d want=1", done_cnt[0] - d0); end
    checks++; if (wn_cnt[0] - w0 != 3) begin failures++; $display("FAIL drop_wnext got=%0d want=3", wn_cnt[0] - w0); end
    checks++; if (go_cnt - g0 != 1) begin failures++; $display("FAIL drop_go_count got=%0d want=1", go_cnt - g0); end
    model_last = 0;
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 8; r++) run_round(NREQ'($urandom_range(1, 15)), "rnd");
  endtask

  task automatic test_reset_mid();
    int n;
    set_req(1, 1'b0, 6'd6, 7'h2A, 8'h07);
    n = 0;
    while (!(mst_phase == 2 && mst_left < 5) && n < 50) begin cycle(); n++; end
    rst_drv = 1'b1; rq_go = '0;
    cycle();
    rst_drv = 1'b0; master_idle();
    cycle();
    checks++; if (grant !== '0) begin failures++; $display("FAIL midrst_grant got=%b want=0", grant); end
    checks++; if (m_go !== 1'b0) begin failures++; $display("FAIL midrst_m_go got=%b want=0", m_go); end
    checks++; if (req_done !== '0) begin failures++; $display("FAIL midrst_done got=%b want=0", req_done); end
    model_last = 0;
    run_round(4'b0011, "postrst");
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    mst_stuck = 1'b1;
    set_req(2, 1'b0, 6'd2, 7'h60, 8'h09);
    wait_done(total_done() + 1, TMO_CYC + 60, ok);
    checks++;
    if (!ok || done_cyc[2] - go_cyc != TMO_CYC + 1) begin
      failures++; $display("FAIL tmo_latency got=%0d want=%0d", done_cyc[2] - go_cyc, TMO_CYC + 1);
    end
    checks++; if (done_err[2] !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b want=1", done_err[2]); end
    mst_stuck = 1'b0; master_idle();
    model_last = 2;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_drv = 1'b1; rq_go = '0; mst_err_inject = 0; mst_both = 0; mst_stuck = 0;
    go_cnt = 0; go_cyc = 0; go_grant = '0; go_rw = 0; go_nb = '0; go_dev = '0; go_rptr = '0;
    mst_drd = 8'h00; master_idle();
    for (int i = 0; i < NREQ; i++) begin
      rq_rw[i] = 0; rq_nb[i] = '0; rq_dev[i] = '0; rq_rptr[i] = '0; rq_wptr[i] = 0;
      done_cnt[i] = 0; done_cyc[i] = 0; wn_cnt[i] = 0; done_err[i] = 0;
      for (int k = 0; k < 64; k++) wbytes[i][k] = 8'h00;
    end
    reset = 1'b1; req_go = '0; req_rw = '0; req_nbyte = '0; req_dev = '0;
    req_rptr = '0; req_wdata = '0; m_ready = 1; m_done = 1; m_wnext = 0;
    m_rvld = 0; m_drd = 0; m_ack_e = 0;

    test_reset();
    test_write();
    test_read();
    test_nbyte0();
    test_all_req();
    test_ack_err();
    test_both_strobes();
    test_drop_go();
    test_random_rounds();
    test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
